// File: rtl/l2_cache_pkg.sv
// rtl/l2_cache_pkg.sv - shared state encoding and sizing helper for the L2 cache
package l2_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WBACK,
    FILL,
    RESPOND
  } state_t;

  function automatic int idx_w(input int num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

endpackage

// File: rtl/l2_cache_array.sv
// rtl/l2_cache_array.sv - tag/data/valid/dirty storage, one word per line
module l2_cache_array
  import l2_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 24,
  parameter int NUM_LINES  = 256,
  parameter int IDX_W      = idx_w(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_dirty
);

  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];
  logic [NUM_LINES-1:0]  valid;
  logic [NUM_LINES-1:0]  dirty;

  // Tag and data arrays carry no reset; only the state bits are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx]  <= wr_tag;
      data_mem[idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= wr_dirty;
    end
  end

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

endmodule

// File: rtl/l2_cache.sv
// rtl/l2_cache.sv - direct-mapped write-back write-allocate L2 cache, one word per line
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LINES  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] l1_addr,
  input  logic [DATA_WIDTH-1:0] l1_data_in,
  input  logic                  l1_read,
  input  logic                  l1_write,
  output logic [DATA_WIDTH-1:0] l1_data_out,
  output logic                  l1_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_ready
);

  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  state_t                state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_write;

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  line_valid;
  logic                  line_dirty;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  hit;
  logic                  victim_dirty;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_dirty;

  assign req_idx      = req_addr[IDX_W-1:0];
  assign req_tag      = req_addr[ADDR_WIDTH-1:IDX_W];
  assign hit          = line_valid && (line_tag == req_tag);
  assign victim_dirty = line_valid && line_dirty;

  l2_cache_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .TAG_W     (TAG_W),
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .idx     (req_idx),
    .rd_valid(line_valid),
    .rd_dirty(line_dirty),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .wr_en   (wr_en),
    .wr_tag  (req_tag),
    .wr_data (wr_data),
    .wr_dirty(wr_dirty)
  );

  // Every line update installs the request tag: write hit/allocate is dirty, a fill is clean.
  always_comb begin
    wr_en    = 1'b0;
    wr_data  = req_data;
    wr_dirty = 1'b1;
    case (state)
      LOOKUP:  wr_en = req_write && (hit || !victim_dirty);
      WBACK:   wr_en = req_write && mem_ready;
      FILL: begin
        wr_en    = mem_ready;
        wr_data  = mem_data_in;
        wr_dirty = 1'b0;
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      l1_ready     <= 1'b0;
      l1_data_out  <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
    end else begin
      l1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (l1_read || l1_write) begin
            req_addr  <= l1_addr;
            req_data  <= l1_data_in;
            req_write <= l1_write;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (!req_write) l1_data_out <= line_data;
            l1_ready <= 1'b1;
            state    <= RESPOND;
          end else if (victim_dirty) begin
            mem_write    <= 1'b1;
            mem_addr     <= {line_tag, req_idx};
            mem_data_out <= line_data;
            state        <= WBACK;
          end else if (req_write) begin
            l1_ready <= 1'b1;
            state    <= RESPOND;
          end else begin
            mem_read <= 1'b1;
            mem_addr <= req_addr;
            state    <= FILL;
          end
        end
        WBACK: begin
          // The fill request is raised on the same edge mem_write drops, so they never overlap.
          if (mem_ready) begin
            mem_write <= 1'b0;
            if (req_write) begin
              l1_ready <= 1'b1;
              state    <= RESPOND;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= req_addr;
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            mem_read    <= 1'b0;
            l1_data_out <= mem_data_in;
            l1_ready    <= 1'b1;
            state       <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache.sv
// tb/tb_l2_cache.sv - randomized and directed bench for l2_cache against a behavioural cache/memory model
module tb_l2_cache;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mop_t;

  logic        clk;
  logic        rst;
  logic [31:0] l1_addr;
  logic [31:0] l1_data_in;
  logic        l1_read;
  logic        l1_write;
  logic [31:0] l1_data_out;
  logic        l1_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_img [bit [31:0]];
  bit          m_valid [256];
  bit          m_dirty [256];
  logic [23:0] m_tag   [256];
  logic [31:0] m_data  [256];
  mop_t        exp_ops [$];
  mop_t        act_log [$];
  bit          in_txn = 1'b0;
  bit          mon_en = 1'b0;
  bit          prev_ready = 1'b0;
  int          mcount = 0;

  l2_cache u_dut (
    .clk         (clk),
    .rst         (rst),
    .l1_addr     (l1_addr),
    .l1_data_in  (l1_data_in),
    .l1_read     (l1_read),
    .l1_write    (l1_write),
    .l1_data_out (l1_data_out),
    .l1_ready    (l1_ready),
    .mem_addr    (mem_addr),
    .mem_data_out(mem_data_out),
    .mem_data_in (mem_data_in),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_ready   (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Memory: mem_ready pulses in the third cycle a request is seen high.
  always begin
    mop_t cur;
    mop_t e;
    @(posedge clk);
    #1;
    if (mem_ready) begin
      mem_ready = 1'b0;
      mcount    = 0;
    end
    if (mem_read || mem_write) begin
      if (mcount == 0) begin
        cur.is_wr = mem_write;
        cur.addr  = mem_addr;
        cur.data  = mem_write ? mem_data_out : 32'h0;
        act_log.push_back(cur);
        if (exp_ops.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_mem_op: got wr=%0d addr 0x%08h, expected no memory traffic", cur.is_wr, cur.addr);
        end else begin
          e = exp_ops.pop_front();
          chk("mem_op_kind", 32'(cur.is_wr), 32'(e.is_wr));
          chk("mem_op_addr", cur.addr, e.addr);
          if (e.is_wr) chk("mem_wb_data", cur.data, e.data);
        end
      end
      mcount++;
      if (mcount == 3) begin
        mem_ready = 1'b1;
        if (mem_write) mem_img[mem_addr] = mem_data_out;
        else mem_data_in = mem_val(mem_addr);
      end
    end else begin
      mcount = 0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mem_rw_exclusive", 32'(mem_read & mem_write), 32'h0);
      if (!in_txn) chk("unexpected_l1_ready", 32'(l1_ready), 32'h0);
      else if (l1_ready && prev_ready) chk("l1_ready_pulse_width", 32'h2, 32'h1);
      prev_ready = l1_ready;
    end
  end

  task automatic predict(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] erd, output int elat);
    int          idx;
    logic [23:0] tg;
    int          n;
    idx = {24'h0, addr[7:0]};
    tg  = addr[31:8];
    n   = 0;
    erd = '0;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      if (wr) begin
        m_data[idx]  = data;
        m_dirty[idx] = 1'b1;
      end else begin
        erd = m_data[idx];
      end
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_ops.push_back('{1'b1, {m_tag[idx], addr[7:0]}, m_data[idx]});
        n++;
      end
      if (wr) begin
        m_data[idx]  = data;
        m_dirty[idx] = 1'b1;
      end else begin
        exp_ops.push_back('{1'b0, addr, 32'h0});
        n++;
        erd          = mem_val(addr);
        m_data[idx]  = erd;
        m_dirty[idx] = 1'b0;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    elat = 2 + 3 * n;
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output int lat, output int nops);
    logic [31:0] exp_rdata;
    int          exp_lat;
    predict(wr, addr, data, exp_rdata, exp_lat);
    act_log.delete();
    l1_addr    = addr;
    l1_data_in = data;
    l1_read    = rd;
    l1_write   = wr;
    in_txn     = 1'b1;
    lat        = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!l1_ready && lat < 100);
    rdata = l1_data_out;
    nops  = act_log.size();
    if (!l1_ready) begin
      chk("l1_ready_timeout", 32'(lat), 32'(exp_lat));
    end else begin
      chk("latency", 32'(lat), 32'(exp_lat));
      if (!wr) chk("read_data", rdata, exp_rdata);
      chk("mem_ops_outstanding", 32'(exp_ops.size()), 32'h0);
    end
    @(posedge clk);
    #1;
    l1_read  = 1'b0;
    l1_write = 1'b0;
    in_txn   = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    rst      = 1'b1;
    l1_read  = 1'b0;
    l1_write = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_ops.delete();
  endtask

  initial begin
    logic [31:0] rdata;
    logic [31:0] a;
    logic [23:0] tg;
    int          lat;
    int          nops;
    int          k;
    int          r;
    int          tsel;

    rst         = 1'b1;
    l1_addr     = '0;
    l1_data_in  = '0;
    l1_read     = 1'b0;
    l1_write    = 1'b0;
    mem_data_in = '0;
    mem_ready   = 1'b0;
    mem_img[32'h10] = 32'hDEADBEEF;

    apply_reset(3);
    chk("rst_l1_ready", 32'(l1_ready), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_l1_data_out", l1_data_out, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_data_out", mem_data_out, 32'h0);
    mon_en = 1'b1;

    // cold read miss, then reread hit
    do_req(1'b1, 1'b0, 32'h10, 32'h0, rdata, lat, nops);
    chk("cold_miss_data", rdata, 32'hDEADBEEF);
    chk("cold_miss_ops", 32'(nops), 32'h1);
    chk("cold_miss_fill_addr", act_log[0].addr, 32'h10);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, rdata, lat, nops);
    chk("reread_latency", 32'(lat), 32'h2);
    chk("reread_ops", 32'(nops), 32'h0);

    // write hit
    do_req(1'b0, 1'b1, 32'h10, 32'h12345678, rdata, lat, nops);
    chk("write_hit_latency", 32'(lat), 32'h2);
    chk("write_hit_ops", 32'(nops), 32'h0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, rdata, lat, nops);
    chk("write_hit_readback", rdata, 32'h12345678);

    // dirty conflict: write-back then fill
    do_req(1'b1, 1'b0, 32'h110, 32'h0, rdata, lat, nops);
    chk("conflict_ops", 32'(nops), 32'h2);
    chk("conflict_wb_kind", 32'(act_log[0].is_wr), 32'h1);
    chk("conflict_wb_addr", act_log[0].addr, 32'h10);
    chk("conflict_wb_data", act_log[0].data, 32'h12345678);
    chk("conflict_fill_kind", 32'(act_log[1].is_wr), 32'h0);
    chk("conflict_fill_addr", act_log[1].addr, 32'h110);
    chk("conflict_latency", 32'(lat), 32'h8);

    // clean write miss allocates without memory traffic
    do_req(1'b0, 1'b1, 32'h20, 32'hCAFE0001, rdata, lat, nops);
    chk("clean_wmiss_latency", 32'(lat), 32'h2);
    chk("clean_wmiss_ops", 32'(nops), 32'h0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, rdata, lat, nops);
    chk("clean_wmiss_readback", rdata, 32'hCAFE0001);

    // reset while a fill is outstanding
    exp_ops.push_back('{1'b0, 32'h40, 32'h0});
    l1_addr = 32'h40;
    l1_read = 1'b1;
    k = 0;
    while (!mem_read && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("fill_started", 32'(mem_read), 32'h1);
    rst     = 1'b1;
    l1_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_fill_mem_read", 32'(mem_read), 32'h0);
    chk("rst_fill_mem_addr", mem_addr, 32'h0);
    chk("rst_fill_l1_ready", 32'(l1_ready), 32'h0);
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_ops.delete();
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    do_req(1'b1, 1'b0, 32'h10, 32'h0, rdata, lat, nops);
    chk("post_rst_miss_ops", 32'(nops), 32'h1);
    chk("post_rst_miss_data", rdata, 32'h12345678);

    // read and write together: write wins
    do_req(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, rdata, lat, nops);
    chk("rw_both_latency", 32'(lat), 32'h2);
    do_req(1'b1, 1'b0, 32'h30, 32'h0, rdata, lat, nops);
    chk("rw_both_readback", rdata, 32'hA5A5A5A5);

    for (int t = 0; t < 400; t++) begin
      r    = $urandom_range(0, 9);
      tsel = $urandom_range(0, 4);
      tg   = (tsel == 4) ? 24'($urandom) : 24'(tsel);
      a    = {tg, 8'($urandom_range(0, 7) * 37)};
      if (r < 5) do_req(1'b1, 1'b0, a, 32'h0, rdata, lat, nops);
      else if (r < 9) do_req(1'b0, 1'b1, a, $urandom, rdata, lat, nops);
      else do_req(1'b1, 1'b1, a, $urandom, rdata, lat, nops);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
